// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Drives a shared decoder with per-digit dwell and inter-digit blanking.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_en,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_tick
);

  typedef enum logic [0:0] {
    DISP  = 1'b0,
    GUARD = 1'b1
  } state_t;

  localparam logic [31:0] DISP_LAST  = 32'(REFRESH_DIV - 1);
  localparam logic [31:0] GUARD_LAST =
    (GUARD_CYC == 0) ? 32'd0 : 32'(GUARD_CYC - 1);
  localparam bit NO_GUARD = (GUARD_CYC == 0);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        adv;
  logic        tick_q;
  logic [3:0]  digit_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISP;
      cnt_q   <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tick_q  <= adv && (sel_q == 3'd7);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    adv     = 1'b0;
    case (state_q)
      DISP: begin
        if (cnt_q == DISP_LAST) begin
          cnt_d = '0;
          if (NO_GUARD) adv = 1'b1;
          else          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          adv     = 1'b1;
          state_d = DISP;
        end
      end
      default: begin
        state_d = DISP;
        cnt_d   = '0;
      end
    endcase
    sel_d = adv ? sel_q + 3'd1 : sel_q;
  end

  // Writes share the edge with a sel advance, so num sees both at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
    end else if (wr_en) begin
      digit_q[wr_addr] <= wr_data;
    end
  end

  assign sel        = sel_q;
  assign num        = digit_q[sel_q];
  assign blank      = (state_q == GUARD) || !digit_en[sel_q];
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without guard)
// checked every cycle against a time-based reference model.
module tb_seg_scan_ctrl;

  localparam int RD    = 4;
  localparam int GC    = 2;
  localparam int SLOT  = RD + GC;
  localparam int FRAME = 8 * SLOT;
  localparam int FRB   = 8 * RD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] digit_en;

  logic [3:0] num_a, num_b;
  logic [2:0] sel_a, sel_b;
  logic       blank_a, blank_b;
  logic       tick_a, tick_b;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(GC)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .digit_en(digit_en),
    .num(num_a), .sel(sel_a), .blank(blank_a), .frame_tick(tick_a)
  );

  seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .digit_en(digit_en),
    .num(num_b), .sel(sel_b), .blank(blank_b), .frame_tick(tick_b)
  );

  always #5 clk = ~clk;

  // Model: t = clock edges since reset release; digit contents array
  logic [3:0] mdig [8];
  int t;
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    int sa;
    int sb;
    int ph;
    sa = (t / SLOT) % 8;
    ph = t % SLOT;
    sb = (t / RD) % 8;
    chk("sel_a",   32'(sel_a),   32'(sa));
    chk("num_a",   32'(num_a),   32'(mdig[sa]));
    chk("blank_a", 32'(blank_a), 32'((ph >= RD) || !digit_en[sa]));
    chk("tick_a",  32'(tick_a),  32'(t > 0 && t % FRAME == 0));
    chk("sel_b",   32'(sel_b),   32'(sb));
    chk("num_b",   32'(num_b),   32'(mdig[sb]));
    chk("blank_b", 32'(blank_b), 32'(!digit_en[sb]));
    chk("tick_b",  32'(tick_b),  32'(t > 0 && t % FRB == 0));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && wr_en) mdig[wr_addr] = wr_data;
    #1;
    if (rst_n) t++;
    check_all();
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 8; i++) mdig[i] = 4'h0;
  endtask

  task automatic reset_with_junk_writes(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(1, 15));
      step();
    end
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    digit_en = 8'hFF;
    model_reset();
    #2;
    check_all();
    reset_with_junk_writes(3);

    // Blank frame, all digits zero
    for (int i = 0; i < FRAME + 4; i++) step();

    // Load 8..F into the digit registers
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 4'(i + 8);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) step();

    // Partial enable mask
    digit_en = 8'b1010_0101;
    for (int i = 0; i < FRAME; i++) step();
    digit_en = 8'hFF;

    // Overwrite the selected digit mid-DISP
    while (!((t / SLOT) % 8 == 3 && t % SLOT == 1)) step();
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 4'h7;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < SLOT; i++) step();

    // Random writes and enable masks
    for (int i = 0; i < 300; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) digit_en = 8'($urandom);
      step();
    end
    wr_en    = 1'b0;
    digit_en = 8'hFF;

    // Asynchronous reset in the sel=5 guard slot
    while (!((t / SLOT) % 8 == 5 && t % SLOT == RD)) step();
    chk("guard_blank", 32'(blank_a), 32'd1);
    digit_en = 8'hFE;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_all();
    reset_with_junk_writes(2);
    for (int i = 0; i < FRAME + 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, 100000, clk cycles each digit is driven (DISP dwell); legal range >=1.
REQ-002 Parameter GUARD_CYC, 1000, clk cycles all digits are blanked between digits (anti-ghosting); 0 disables the guard.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  digit write strobe; sampled each clk edge; always accepted (no backpressure).
REQ-006 wr_addr  input  3  index of the digit register written.
REQ-007 wr_data  input  4  hex value written.
REQ-008 digit_en  input  8  per-digit enable mask; bit i=0 blanks digit i.
REQ-009 num  output  4  hex value for the shared seven-segment decoder.
REQ-010 sel  output  3  digit select for the shared decoder.
REQ-011 blank  output  1  1 = integration forces an to 8'hFF and seg to 7'h7F.
REQ-012 frame_tick  output  1  one-cycle pulse at the end of each full 8-digit scan.

Function
REQ-013 Eight 4-bit digit registers digit[0..7]; wr_en=1 at an edge loads digit[wr_addr]=wr_data at that edge.
REQ-014 num SHALL equal digit[sel] combinationally from registered state; a write to the currently selected digit is visible on num right after the write edge.
REQ-015 FSM states: DISP, GUARD; 32-bit dwell counter cnt.
REQ-016 DISP: cnt increments each cycle; at cnt==REFRESH_DIV-1 clear cnt and go GUARD (or, if GUARD_CYC==0, directly advance sel and stay DISP).
REQ-017 GUARD: cnt increments each cycle; at cnt==GUARD_CYC-1 clear cnt, advance sel, go DISP.
REQ-018 sel advance: sel = sel+1 modulo 8; 7 wraps to 0.
REQ-019 sel SHALL remain stable throughout DISP and GUARD; it changes only on the advancing edge.
REQ-020 blank = 1 when state==GUARD or digit_en[sel]==0; else 0; combinational from state, sel and digit_en.
REQ-021 Disabled digits still consume their full DISP+GUARD slot (fixed scan period 8*(REFRESH_DIV+GUARD_CYC) cycles).
REQ-022 frame_tick registered; high for exactly the one cycle following the edge on which sel wraps 7->0; low otherwise.
REQ-023 wr_en and digit_en do not affect FSM, cnt or sel timing.
REQ-024 Write coinciding with a sel advance: both take effect at the same edge; num reflects new sel with updated register contents.

Reset
REQ-025 rst_n=0 SHALL immediately (no clk required) set state=DISP, cnt=0, sel=0, digit[0..7]=0, frame_tick=0; hence num=0, blank=~digit_en[0].
REQ-026 Reset asserted mid-DISP or mid-GUARD aborts the slot; after release scanning restarts at sel=0 with a full DISP dwell.
REQ-027 Writes presented while rst_n=0 are ignored.

Verification (bench uses REFRESH_DIV=4, GUARD_CYC=2, digit_en=8'hFF unless stated)
REQ-028 Reset release, no writes -> sel=0, num=0, blank=0 for 4 cycles, blank=1 for 2 cycles, then sel=1; sel sequence 0..7,0 with 6-cycle slots.
REQ-029 Write digit[i]=i+8 for i=0..7, then observe a frame -> num shows 8,9,A,B,C,D,E,F in sel order 0..7; frame_tick pulses once per 48 cycles, in the cycle after sel returns to 0.
REQ-030 digit_en=8'b1010_0101 -> blank=1 throughout slots for sel=1,3,4,6; those slots still last 6 cycles; enabled slots show blank=0 for 4 cycles then 1 for 2.
REQ-031 While sel=3 in DISP, write wr_addr=3, wr_data=4'h7 -> num changes to 7 right after that edge; sel and cnt timing unaffected.
REQ-032 Assert rst_n=0 mid-GUARD with sel=5 -> sel=0, blank=~digit_en[0], all digits read 0 immediately; after release sel=0 holds for full 4-cycle DISP.
REQ-033 Instance with GUARD_CYC=0 -> blank never asserted by FSM; sel advances every 4 cycles; frame_tick every 32 cycles.
